// File: rtl/spectro_line_binner.sv
// Sums groups of 2^BIN_LOG2 pixel samples into framed words and buffers them in a
// show-ahead FIFO. The upstream stream cannot stall, so a full FIFO drops words.
module spectro_line_binner #(
  parameter int unsigned PIXELS_PER_LINE = 2048,
  parameter int unsigned BIN_LOG2        = 2,
  parameter int unsigned OUT_DEPTH       = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [9:0]  dataIn,
  input  logic        dataValid,
  output logic [15:0] outData,
  output logic        outLast,
  output logic        outValid,
  input  logic        outReady,
  output logic        overflow,
  input  logic        clearOverflow,
  output logic [15:0] lineCount
);

  localparam int unsigned BinSize = 1 << BIN_LOG2;
  localparam int unsigned PixW    = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam int unsigned PtrW    = $clog2(OUT_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;

  localparam logic [2:0]      BinLast = 3'(BinSize - 1);
  localparam logic [PixW-1:0] PixLast = PixW'(PIXELS_PER_LINE - 1);
  localparam logic [PixW-1:0] PixSol  = PixW'(BinSize - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(OUT_DEPTH);

  logic [2:0]      bin_idx_q, bin_idx_d;
  logic [PixW-1:0] pix_idx_q, pix_idx_d;
  logic [12:0]     acc_q, acc_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic            ovf_q, ovf_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Entry layout: {sol, last, sum[12:0]}
  logic [14:0] mem_q [OUT_DEPTH];
  logic [14:0] head;
  logic [14:0] push_word;

  logic [12:0] sum;
  logic        bin_done;
  logic        push;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;

  always_comb begin
    sum       = ((bin_idx_q == 3'd0) ? 13'd0 : acc_q) + {3'd0, dataIn};
    bin_done  = (bin_idx_q == BinLast);
    push      = dataValid && bin_done;
    pop       = (count_q != '0) && outReady;
    full      = (count_q == CntFull);
    // A same-cycle pop frees the slot the push needs.
    push_ok   = push && (!full || pop);
    drop      = push && full && !pop;
    push_word = {(pix_idx_q == PixSol), (pix_idx_q == PixLast), sum};
  end

  always_comb begin
    bin_idx_d  = bin_idx_q;
    pix_idx_d  = pix_idx_q;
    acc_d      = acc_q;
    line_cnt_d = line_cnt_q;
    if (dataValid) begin
      if (bin_done) begin
        bin_idx_d = 3'd0;
      end else begin
        bin_idx_d = bin_idx_q + 3'd1;
        acc_d     = sum;
      end
      if (pix_idx_q == PixLast) begin
        pix_idx_d  = '0;
        line_cnt_d = line_cnt_q + 16'd1;
      end else begin
        pix_idx_d = pix_idx_q + PixW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Set wins over a simultaneous clear.
    ovf_d = (ovf_q && !clearOverflow) || drop;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bin_idx_q  <= 3'd0;
      pix_idx_q  <= '0;
      acc_q      <= 13'd0;
      line_cnt_q <= 16'd0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      bin_idx_q  <= bin_idx_d;
      pix_idx_q  <= pix_idx_d;
      acc_q      <= acc_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by outValid.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign outValid  = (count_q != '0);
  assign outData   = outValid ? {head[14], 2'b00, head[12:0]} : 16'd0;
  assign outLast   = outValid & head[13];
  assign overflow  = ovf_q;
  assign lineCount = line_cnt_q;

endmodule

// File: tb/tb_spectro_line_binner.sv
// Self-checking bench for spectro_line_binner: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_spectro_line_binner;

  localparam int PPL   = 8;
  localparam int BIN   = 2;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [9:0]  dataIn = '0;
  logic        dataValid = 1'b0;
  logic        outReady = 1'b0;
  logic        clearOverflow = 1'b0;
  logic [15:0] outData;
  logic        outLast;
  logic        outValid;
  logic        overflow;
  logic [15:0] lineCount;

  logic [9:0]  din8 = '0;
  logic        dv8 = 1'b0;
  logic        rdy8 = 1'b0;
  logic [15:0] out8_data;
  logic        out8_last;
  logic        out8_valid;
  logic        ovf8;
  logic [15:0] line8;

  spectro_line_binner #(.PIXELS_PER_LINE(PPL), .BIN_LOG2(1), .OUT_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .dataIn        (dataIn),
    .dataValid     (dataValid),
    .outData       (outData),
    .outLast       (outLast),
    .outValid      (outValid),
    .outReady      (outReady),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .lineCount     (lineCount)
  );

  spectro_line_binner #(.PIXELS_PER_LINE(8), .BIN_LOG2(3), .OUT_DEPTH(4)) dut8 (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .dataIn        (din8),
    .dataValid     (dv8),
    .outData       (out8_data),
    .outLast       (out8_last),
    .outValid      (out8_valid),
    .outReady      (rdy8),
    .overflow      (ovf8),
    .clearOverflow (1'b0),
    .lineCount     (line8)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit dv;
    int din;
    bit rdy;
    bit ev;
    int edata;
    bit elast;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  // Reference model: FIFO contents as {last, outData}, plus the samples of the open bin.
  int   m_q[$];
  int   m_bin[$];
  int   m_pix;
  int   m_lines;
  bit   m_ovf;
  int   got[$];
  int   line_words[4] = '{32'h8003, 32'h0007, 32'h000B, 32'h1000F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bin.delete();
    m_pix   = 0;
    m_lines = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit dv, input int din, input bit rdy, input bit clr);
    bit pop;
    bit full;
    int sum;
    int w;
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() >= DEPTH);
    if (clr) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (dv) begin
      m_bin.push_back(din);
      m_pix++;
      if (m_bin.size() == BIN) begin
        sum = 0;
        foreach (m_bin[i]) sum += m_bin[i];
        w = sum | ((m_pix == BIN) ? 32'h8000 : 0) | ((m_pix == PPL) ? 32'h10000 : 0);
        if (!full || pop) m_q.push_back(w);
        else m_ovf = 1'b1;
        m_bin.delete();
      end
      if (m_pix == PPL) begin
        m_pix   = 0;
        m_lines = (m_lines + 1) % 65536;
      end
    end
  endtask

  task automatic model_check();
    chk("valid", 32'(outValid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("data", 32'(outData), m_q[0] & 32'hFFFF);
      chk("last", 32'(outLast), m_q[0] >> 16);
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("lineCount", 32'(lineCount), m_lines);
  endtask

  // One clock: drive, capture any handshake, step model at the edge, check after it.
  task automatic cycle(input bit dv, input logic [9:0] din, input bit rdy, input bit clr);
    dataValid     = dv;
    dataIn        = din;
    outReady      = rdy;
    clearOverflow = clr;
    if (outValid && rdy) got.push_back(int'({outLast, outData}));
    @(posedge CLK);
    model_step(dv, int'(din), rdy, clr);
    #1;
    model_check();
  endtask

  task automatic check_line_words(input string name);
    chk({name, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk(name, got[i], line_words[i]);
    end
  endtask

  task automatic apply_table();
    got.delete();
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].dv, 10'(vecs[i].din), vecs[i].rdy, 1'b0);
      chk("tbl_valid", 32'(outValid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk("tbl_data", 32'(outData), vecs[i].edata);
        chk("tbl_last", 32'(outLast), 32'(vecs[i].elast));
      end
    end
    check_line_words("tbl_drain");
  endtask

  // Reset pulse asserted and released away from the clock edge.
  task automatic reset_pulse();
    dataValid     = 1'b0;
    outReady      = 1'b0;
    clearOverflow = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("rst_valid", 32'(outValid), 0);
    chk("rst_data", 32'(outData), 0);
    chk("rst_last", 32'(outLast), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_lines", 32'(lineCount), 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    chk("rst_valid_hold", 32'(outValid), 0);
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 1, 1, 0, 0, 0};
    vecs[1] = '{1, 2, 1, 1, 32'h8003, 0};
    vecs[2] = '{1, 3, 1, 0, 0, 0};
    vecs[3] = '{1, 4, 1, 1, 32'h0007, 0};
    vecs[4] = '{1, 5, 1, 0, 0, 0};
    vecs[5] = '{1, 6, 1, 1, 32'h000B, 0};
    vecs[6] = '{1, 7, 1, 0, 0, 0};
    vecs[7] = '{1, 8, 1, 1, 32'h000F, 1};
    vecs[8] = '{0, 0, 1, 0, 0, 0};

    model_reset();
    #1;
    chk("init_valid", 32'(outValid), 0);
    chk("init_data", 32'(outData), 0);
    chk("init_lines", 32'(lineCount), 0);
    chk("init_ovf", 32'(overflow), 0);
    #11 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Basic line 1..8
    apply_table();
    chk("t1_lines", 32'(lineCount), 1);
    chk("t1_ovf", 32'(overflow), 0);

    // Gapped valid with garbage on invalid cycles
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 10'($urandom), 1'b1, 1'b0);
      cycle(1'b1, 10'(i), 1'b1, 1'b0);
    end
    cycle(1'b0, 10'($urandom), 1'b1, 1'b0);
    cycle(1'b0, 10'($urandom), 1'b1, 1'b0);
    check_line_words("gap");

    // Mid-line reset with a word pending in the FIFO
    for (int i = 1; i <= 3; i++) cycle(1'b1, 10'(i), 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(outValid), 1);
    reset_pulse();
    apply_table();

    // Overflow: two lines with consumer stalled
    reset_pulse();
    for (int l = 0; l < 2; l++) begin
      for (int i = 1; i <= 8; i++) cycle(1'b1, 10'(i), 1'b0, 1'b0);
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_lines", 32'(lineCount), 2);
    chk("ovf_head", 32'(outData), 32'h8003);
    // Clear coincides with a further drop on the final word of line 3
    for (int i = 1; i <= 7; i++) cycle(1'b1, 10'(i), 1'b0, 1'b0);
    cycle(1'b1, 10'd8, 1'b0, 1'b1);
    chk("ovf_clr_vs_drop", 32'(overflow), 1);
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 0);
    got.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 10'd0, 1'b1, 1'b0);
    check_line_words("ovf_drain");
    chk("ovf_empty", 32'(outValid), 0);
    cycle(1'b1, 10'd1, 1'b1, 1'b0);
    cycle(1'b1, 10'd2, 1'b1, 1'b0);
    chk("realign_sol", 32'(outData), 32'h8003);
    for (int i = 3; i <= 8; i++) cycle(1'b1, 10'(i), 1'b1, 1'b0);
    cycle(1'b0, 10'd0, 1'b1, 1'b0);

    // Bin of 8 at full scale on the second instance
    dataValid = 1'b0;
    outReady  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dv8  = 1'b1;
      din8 = 10'd1023;
      @(posedge CLK);
      #1;
    end
    dv8 = 1'b0;
    chk("b8_valid", 32'(out8_valid), 1);
    chk("b8_data", 32'(out8_data), 32'h9FF8);
    chk("b8_last", 32'(out8_last), 1);
    chk("b8_lines", 32'(line8), 1);
    rdy8 = 1'b1;
    @(posedge CLK);
    #1;
    rdy8 = 1'b0;
    chk("b8_empty", 32'(out8_valid), 0);

    // Randomized traffic, first phase back-pressured hard to provoke drops
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) != 0, 10'($urandom_range(0, 1023)),
            (i < 500) ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
            ($urandom % 16) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spectro_line_binner.md
# spectro_line_binner

Downstream consumer of the spectrometer FIFO reader's `dataOut`/`dataValid` stream. It sums groups of 2^BIN_LOG2 consecutive 10-bit pixel samples into binned words and tags the start and end of each spectrometer line. Results are buffered in a small show-ahead output FIFO behind a ready/valid handshake. The upstream stage cannot be stalled, so a full buffer drops words, sets a sticky overflow flag, and keeps line alignment intact.

## Interface
Parameters:
- PIXELS_PER_LINE, 2048: samples per spectrometer line. Must be a multiple of 2^BIN_LOG2 and ≥ 2^BIN_LOG2.
- BIN_LOG2, 2: log2 of the bin size. Legal range 0..3, giving bins of 1, 2, 4 or 8 samples.
- OUT_DEPTH, 8: output FIFO entries. Power of two, ≥ 2.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- dataIn  in  10  pixel sample from the FIFO reader.
- dataValid  in  1  dataIn is valid this cycle. Sampled at every rising edge.
- outData  out  16  head word of the FIFO: [15] = SOL (first word of line), [14:13] = 0, [12:0] = bin sum, zero-extended.
- outLast  out  1  head word is the final word of a line.
- outValid  out  1  FIFO not empty.
- outReady  in  1  consumer accepts the head word when outValid && outReady.
- overflow  out  1  sticky: at least one word has been dropped.
- clearOverflow  in  1  synchronous clear of overflow.
- lineCount  out  16  number of completed lines. Wraps 65535 → 0.

## Operation
- Internal state:
  - binIdx: 0..2^BIN_LOG2-1.
  - pixIdx: 0..PIXELS_PER_LINE-1.
  - acc: 13 bits.
  - Output FIFO storing {SOL, last, 13-bit sum}.
- On each cycle with dataValid=1:
  - sum = (binIdx==0 ? 0 : acc) + dataIn. The 13-bit width cannot overflow, since 8 × 1023 = 8184.
  - If binIdx is the last index, a word is pushed with sum, SOL = (pixIdx == 2^BIN_LOG2-1), and last = (pixIdx == PIXELS_PER_LINE-1). binIdx then returns to 0.
  - Otherwise acc ← sum and binIdx increments.
  - pixIdx increments and wraps to 0 after PIXELS_PER_LINE-1. On that wrap, lineCount increments.
- Cycles with dataValid=0 change no counter or accumulator.
- Push acceptance:
  - A push is accepted if the FIFO count < OUT_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow ← 1.
  - A dropped word does not stall or alter binIdx, pixIdx or lineCount. Line framing stays aligned.
- Pop happens when outValid && outReady. Simultaneous push and pop leaves the count unchanged.
- overflow:
  - Cleared by clearOverflow=1.
  - If a drop occurs in the same cycle as clearOverflow, the set wins and overflow stays 1.
- BIN_LOG2=0: every sample becomes its own word.
- Mid-line reset: all state is discarded. The next valid sample is treated as pixel 0 of a new line.

## Timing
- Reset (RST_N low, asynchronous): outValid=0, outData=0, outLast=0, overflow=0, lineCount=0, FIFO empty, all counters and acc = 0.
- Latency: the word completed by a sample captured at edge N is visible at the head (outValid=1 if the FIFO was empty) immediately after edge N, i.e. one cycle after dataValid.
- outData and outLast come from the FIFO head (show-ahead). They hold stable while outValid && !outReady.
- lineCount and overflow update at the same edge as the word that causes them.
- Throughput: one sample per cycle sustained. Output worst case is one word per cycle when BIN_LOG2=0.

## Test plan
- PIXELS_PER_LINE=8, BIN_LOG2=1, OUT_DEPTH=4, outReady=1; feed samples 1..8 back-to-back.
  - Required: outData = 0x8003, 0x0007, 0x000B, 0x000F.
  - outLast=1 only on 0x000F; lineCount=1; overflow=0.
- PIXELS_PER_LINE=8, BIN_LOG2=3; feed eight samples of 1023.
  - Required: a single word 0x9FF8 with outLast=1.
- Config as test 1, outReady=0; feed two lines (1..8 twice).
  - Required: the FIFO holds 0x8003, 0x0007, 0x000B, 0x000F; overflow=1; lineCount=2.
  - After raising outReady, exactly those 4 words drain, then outValid=0.
  - A third line then produces 0x8003 first.
- Config as test 1; feed 1..8 with dataValid toggling every other cycle and random values on dataIn when invalid.
  - Required: output identical to test 1.
- Config as test 1; feed 3 samples, pulse RST_N low for one cycle mid-cycle, then feed 1..8.
  - Required: all outputs 0 during reset (asynchronous); output identical to test 1 afterwards.
- Config as test 3 with overflow=1; hold clearOverflow=1 during the cycle of a further drop.
  - Required: overflow stays 1.
  - clearOverflow with no drop clears it to 0 on the next edge.
